// File: rtl/display_arbiter.sv
// Shares a 4-digit seven-segment display between three requesters. It uses a fixed-priority
// arbiter with a minimum hold time, converts the owner's value to BCD by repeated subtraction, and scans the digits.
module display_arbiter #(
   parameter int         SCAN_DIV    = 131072,
   parameter int         HOLD_FRAMES = 4,
   parameter logic [3:0] BLANK       = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [6:0] val0,
   input  logic [6:0] val1,
   input  logic [6:0] val2,
   output logic [2:0] grant,
   output logic [3:0] digit,
   output logic [1:0] an_sel,
   output logic       busy
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [SCAN_W-1:0] SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW} state_t;

   state_t            state_q;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        an_sel_q, an_sel_d;
   logic [3:0]        digit_q, digit_d;
   logic [2:0]        grant_q;
   logic              busy_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [6:0]        work_q;
   logic [3:0]        tens_acc_q;
   logic [3:0]        ones_q, tens_q, id_q;

   logic       scan_tc, frame_end;
   logic [1:0] top_idx, owner_idx;
   logic [2:0] top_oh;
   logic [6:0] top_raw, owner_raw, top_val, owner_val;
   logic       owner_req, higher_req;

   always_comb begin
      scan_tc    = (scan_cnt_q == SCAN_TC);
      frame_end  = scan_tc && (an_sel_q == 2'd3);
      scan_cnt_d = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
      an_sel_d   = scan_tc ? an_sel_q + 2'd1 : an_sel_q;
      // The digit register follows the slot that an_sel is about to enter.
      digit_d = digit_q;
      if (scan_tc) begin
         case (an_sel_d)
            2'd0:    digit_d = ones_q;
            2'd1:    digit_d = tens_q;
            2'd2:    digit_d = id_q;
            default: digit_d = BLANK;
         endcase
      end
   end

   always_comb begin
      top_idx = 2'd0;
      if (req[2])      top_idx = 2'd2;
      else if (req[1]) top_idx = 2'd1;
      top_oh    = 3'b001 << top_idx;
      owner_idx = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
      case (top_idx)
         2'd2:    top_raw = val2;
         2'd1:    top_raw = val1;
         default: top_raw = val0;
      endcase
      case (owner_idx)
         2'd2:    owner_raw = val2;
         2'd1:    owner_raw = val1;
         default: owner_raw = val0;
      endcase
      top_val    = (top_raw > 7'd99) ? 7'd99 : top_raw;
      owner_val  = (owner_raw > 7'd99) ? 7'd99 : owner_raw;
      owner_req  = |(req & grant_q);
      higher_req = (|req) && (top_idx > owner_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         scan_cnt_q <= '0;
         an_sel_q   <= 2'd0;
         digit_q    <= BLANK;
         grant_q    <= 3'b000;
         busy_q     <= 1'b0;
         hold_cnt_q <= '0;
         work_q     <= 7'd0;
         tens_acc_q <= 4'd0;
         ones_q     <= BLANK;
         tens_q     <= BLANK;
         id_q       <= BLANK;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         an_sel_q   <= an_sel_d;
         digit_q    <= digit_d;
         case (state_q)
            S_IDLE: begin
               grant_q <= 3'b000;
               busy_q  <= 1'b0;
               ones_q  <= BLANK;
               tens_q  <= BLANK;
               id_q    <= BLANK;
               if (|req) begin
                  grant_q    <= top_oh;
                  work_q     <= top_val;
                  tens_acc_q <= 4'd0;
                  hold_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               if (work_q >= 7'd10) begin
                  work_q     <= work_q - 7'd10;
                  tens_acc_q <= tens_acc_q + 4'd1;
               end else begin
                  // All three display registers change on one edge; tens==0 is suppressed.
                  ones_q  <= work_q[3:0];
                  tens_q  <= (tens_acc_q == 4'd0) ? BLANK : tens_acc_q;
                  id_q    <= {2'b00, owner_idx};
                  busy_q  <= 1'b0;
                  state_q <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (frame_end && (hold_cnt_q < HOLD_MAX))
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               if (!owner_req) begin
                  if (|req) begin
                     grant_q    <= top_oh;
                     work_q     <= top_val;
                     tens_acc_q <= 4'd0;
                     hold_cnt_q <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= S_CONVERT;
                  end else begin
                     grant_q <= 3'b000;
                     ones_q  <= BLANK;
                     tens_q  <= BLANK;
                     id_q    <= BLANK;
                     state_q <= S_IDLE;
                  end
               end else if ((hold_cnt_q == HOLD_MAX) && higher_req) begin
                  grant_q    <= top_oh;
                  work_q     <= top_val;
                  tens_acc_q <= 4'd0;
                  hold_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_CONVERT;
               end else if (frame_end) begin
                  // Refresh keeps the accumulated hold time.
                  work_q     <= owner_val;
                  tens_acc_q <= 4'd0;
                  busy_q     <= 1'b1;
                  state_q    <= S_CONVERT;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant  = grant_q;
   assign digit  = digit_q;
   assign an_sel = an_sel_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: a vector table of single-owner/priority cases plus
// hand-written sequences for hold time, preemption, release and reset during conversion.
module tb_display_arbiter;
   localparam int SCAN_DIV    = 4;
   localparam int HOLD_FRAMES = 2;
   localparam int FRAME       = 4 * SCAN_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
   logic [6:0] val0 = 7'd0, val1 = 7'd0, val2 = 7'd0;
   logic [2:0] grant;
   logic [3:0] digit;
   logic [1:0] an_sel;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] slot_dig [4];

   typedef struct {
      logic [2:0] req;
      logic [6:0] v0, v1, v2;
      logic [2:0] g;
      logic [3:0] s0, s1, s2;
   } vec_t;
   vec_t vecs [8];

   display_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD_FRAMES), .BLANK(4'hF)) dut (
      .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .val2(val2),
      .grant(grant), .digit(digit), .an_sel(an_sel), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic capture_frame;
      for (int i = 0; i < 4; i++) slot_dig[i] = 4'bxxxx;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         slot_dig[an_sel] = digit;
      end
   endtask

   task automatic check_frame(input string name, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3);
      logic [3:0] e;
      exp_q.push_back(s0);
      exp_q.push_back(s1);
      exp_q.push_back(s2);
      exp_q.push_back(s3);
      capture_frame();
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         check($sformatf("%s_slot%0d", name, i), {28'd0, slot_dig[i]}, {28'd0, e});
      end
   endtask

   task automatic wait_grant(input string name, input logic [2:0] g, input int limit);
      int n;
      n = 0;
      while (grant !== g && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, {29'd0, grant}, {29'd0, g});
   endtask

   task automatic go_idle;
      req = 3'b000;
      cycles(20);
   endtask

   initial begin
      int n;
      vecs[0] = '{3'b001, 7'd47,  7'd0,  7'd0,   3'b001, 4'd7, 4'd4, 4'd0};
      vecs[1] = '{3'b001, 7'd5,   7'd0,  7'd0,   3'b001, 4'd5, 4'hF, 4'd0};
      vecs[2] = '{3'b001, 7'd120, 7'd0,  7'd0,   3'b001, 4'd9, 4'd9, 4'd0};
      vecs[3] = '{3'b010, 7'd0,   7'd99, 7'd0,   3'b010, 4'd9, 4'd9, 4'd1};
      vecs[4] = '{3'b100, 7'd0,   7'd0,  7'd10,  3'b100, 4'd0, 4'd1, 4'd2};
      vecs[5] = '{3'b011, 7'd3,   7'd60, 7'd0,   3'b010, 4'd0, 4'd6, 4'd1};
      vecs[6] = '{3'b111, 7'd1,   7'd2,  7'd0,   3'b100, 4'd0, 4'hF, 4'd2};
      vecs[7] = '{3'b101, 7'd88,  7'd0,  7'd100, 3'b100, 4'd9, 4'd9, 4'd2};

      // Reset held for three edges, released with no requests.
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      check("rst_grant", {29'd0, grant}, 32'd0);
      check("rst_digit", {28'd0, digit}, 32'hF);
      check("rst_an_sel", {30'd0, an_sel}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      cycles(3);
      check("scan_hold", {30'd0, an_sel}, 32'd0);
      cycles(1);
      check("scan_step", {30'd0, an_sel}, 32'd1);
      check_frame("idle", 4'hF, 4'hF, 4'hF, 4'hF);

      for (int i = 0; i < 8; i++) begin
         go_idle();
         val0 = vecs[i].v0;
         val1 = vecs[i].v1;
         val2 = vecs[i].v2;
         req  = vecs[i].req;
         cycles(3 * FRAME);
         check($sformatf("vec%0d_grant", i), {29'd0, grant}, {29'd0, vecs[i].g});
         check_frame($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, 4'hF);
      end

      // Value change while the owner holds: refresh picks it up.
      go_idle();
      val0 = 7'd5;
      req  = 3'b001;
      cycles(3 * FRAME);
      check_frame("refresh_a", 4'd5, 4'hF, 4'd0, 4'hF);
      val0 = 7'd120;
      cycles(3 * FRAME);
      check_frame("refresh_b", 4'd9, 4'd9, 4'd0, 4'hF);
      check("refresh_grant", {29'd0, grant}, 32'b001);

      // Busy lasts five cycles for 47 (four subtractions plus commit).
      go_idle();
      val0 = 7'd47;
      req  = 3'b001;
      @(negedge clk);
      check("busy_grant", {29'd0, grant}, 32'b001);
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("busy_len", n, 32'd5);

      // Higher request must wait for two held frames.
      go_idle();
      val0 = 7'd47;
      val2 = 7'd82;
      req  = 3'b001;
      @(negedge clk);
      check("hold_first_grant", {29'd0, grant}, 32'b001);
      cycles(15);
      req = 3'b101;
      cycles(5);
      check("no_early_preempt", {29'd0, grant}, 32'b001);
      wait_grant("preempt_grant", 3'b100, 80);
      cycles(3 * FRAME);
      check_frame("preempt", 4'd2, 4'd8, 4'd2, 4'hF);

      // Lower-index requests never preempt.
      for (int k = 0; k < 6; k++) begin
         req = (k % 2 == 0) ? 3'b101 : 3'b100;
         cycles(7);
         check($sformatf("no_low_preempt%0d", k), {29'd0, grant}, 32'b100);
      end

      // Owner drop releases on the next edge with no hold wait.
      req = 3'b101;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("show_before_drop", {31'd0, busy}, 32'd0);
      req = 3'b001;
      @(negedge clk);
      check("drop_grant", {29'd0, grant}, 32'b001);
      check("drop_busy", {31'd0, busy}, 32'd1);
      cycles(3 * FRAME);
      check_frame("after_drop", 4'd7, 4'd4, 4'd0, 4'hF);

      // Reset in the middle of a conversion.
      go_idle();
      val1 = 7'd90;
      req  = 3'b010;
      @(negedge clk);
      check("conv_busy", {31'd0, busy}, 32'd1);
      cycles(2);
      rst = 1'b1;
      req = 3'b000;
      @(negedge clk);
      check("mid_rst_grant", {29'd0, grant}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_digit", {28'd0, digit}, 32'hF);
      check("mid_rst_an_sel", {30'd0, an_sel}, 32'd0);
      rst = 1'b0;
      check_frame("post_rst", 4'hF, 4'hF, 4'hF, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
